// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed matrix keypad scanner with frame debounce; optional auto-repeat under KEYPAD_REPEAT_EN
module keypad_scanner #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int SCAN_DIV    = 16,
   parameter int DEBOUNCE    = 8,
   parameter int REPEAT_DLY  = 32,
   parameter int REPEAT_RATE = 8,
   localparam int KEY_W      = $clog2(ROWS*COLS)
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic [COLS-1:0]  i_Col,
   output logic [ROWS-1:0]  o_Row,
   output logic [KEY_W-1:0] o_Key,
   output logic             o_Valid,
   output logic             o_Held,
   output logic             o_Multi
);
   localparam int RW = $clog2(ROWS);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE+1);

   if (ROWS < 2 || COLS < 2 || SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_param_err
      $error("keypad_scanner: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   logic [COLS-1:0]  col_s1_q, col_s2_q;
   logic             active_q;
   logic [RW-1:0]    row_q;
   logic [DW-1:0]    dwell_q;
   logic [1:0]       acc_n_q;
   logic [KEY_W-1:0] acc_k_q;
   logic             acc_kp_q;
   logic             sample, frame_end;
   logic [1:0]       row_n, frame_n;
   logic [KEY_W-1:0] row_k, frame_k;
   logic             row_kp, frame_kp;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KEY_W-1:0] cand_q, cand_d, key_q, key_d;
   logic             valid_q, valid_d, multi_q, multi_d;
`ifdef KEYPAD_REPEAT_EN
   localparam int REPW = $clog2((REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE) + 1);
   logic [REPW-1:0]  rep_q, rep_d;
   logic             first_q, first_d;
`endif

   // Classify the current row sample and fold it into the running frame result (0, 1 or "2+" keys)
   always_comb begin
      row_n  = 2'd0;
      row_k  = '0;
      row_kp = 1'b0;
      for (int c = COLS-1; c >= 0; c--) begin
         if (!col_s2_q[c]) begin
            row_n = (row_n == 2'd0) ? 2'd1 : 2'd2;
            row_k = KEY_W'(int'(row_q)*COLS + c);
            if (KEY_W'(int'(row_q)*COLS + c) == key_q) row_kp = 1'b1;
         end
      end
      sample    = active_q && dwell_q == DW'(SCAN_DIV-1);
      frame_end = sample && row_q == RW'(ROWS-1);
      frame_n   = ({1'b0, acc_n_q} + {1'b0, row_n} > 3'd1) ? 2'd2 : (acc_n_q | row_n);
      frame_k   = (acc_n_q != 2'd0) ? acc_k_q : row_k;
      frame_kp  = acc_kp_q | row_kp;
   end

   // Column synchronizer, row/dwell scan counters and per-frame accumulator; scanning starts one cycle after reset
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         col_s1_q <= '1;
         col_s2_q <= '1;
         active_q <= 1'b0;
         row_q    <= '0;
         dwell_q  <= '0;
         acc_n_q  <= 2'd0;
         acc_k_q  <= '0;
         acc_kp_q <= 1'b0;
      end else begin
         col_s1_q <= i_Col;
         col_s2_q <= col_s1_q;
         active_q <= 1'b1;
         if (active_q) dwell_q <= sample ? '0 : dwell_q + 1'b1;
         if (sample) begin
            row_q    <= frame_end ? '0 : row_q + 1'b1;
            acc_n_q  <= frame_end ? 2'd0 : frame_n;
            acc_k_q  <= frame_end ? '0 : frame_k;
            acc_kp_q <= frame_end ? 1'b0 : frame_kp;
         end
      end
   end

   // Debounce state and registered key-event outputs
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
         key_q   <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= '0;
         first_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         key_q   <= key_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= rep_d;
         first_q <= first_d;
`endif
      end
   end

   // Frame-end transitions; counter thresholds are applied after the case so DEBOUNCE=1 accepts/releases immediately
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      key_d   = key_q;
      valid_d = 1'b0;
      multi_d = frame_end ? (frame_n == 2'd2) : multi_q;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = rep_q;
      first_d = first_q;
`endif
      if (frame_end) begin
         case (state_q)
            S_IDLE: if (frame_n == 2'd1) begin
               state_d = S_DEBOUNCE;
               cand_d  = frame_k;
               cnt_d   = CW'(1);
            end
            S_DEBOUNCE: if (frame_n == 2'd1 && frame_k == cand_q) cnt_d = cnt_q + 1'b1;
               else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            S_PRESSED: if (!frame_kp) begin
               state_d = S_RELEASE;
               cnt_d   = CW'(1);
            end
            S_RELEASE: if (frame_kp) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         endcase
         if (state_d == S_DEBOUNCE && cnt_d >= CW'(DEBOUNCE)) begin
            state_d = S_PRESSED;
            key_d   = cand_d;
            valid_d = 1'b1;
            cnt_d   = '0;
         end
         if (state_d == S_RELEASE && cnt_d >= CW'(DEBOUNCE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
`ifdef KEYPAD_REPEAT_EN
         if (state_q == S_PRESSED && state_d == S_PRESSED) begin
            rep_d = rep_q + 1'b1;
            if (rep_d == (first_q ? REPW'(REPEAT_DLY) : REPW'(REPEAT_RATE))) begin
               valid_d = 1'b1;
               rep_d   = '0;
               first_d = 1'b0;
            end
         end
         if (state_d == S_IDLE) begin
            rep_d   = '0;
            first_d = 1'b1;
         end
`endif
      end
   end

   // Row drive and status outputs
   always_comb begin
      o_Row   = active_q ? ~(ROWS'(1) << row_q) : '1;
      o_Key   = key_q;
      o_Valid = valid_q;
      o_Held  = state_q == S_PRESSED || state_q == S_RELEASE;
      o_Multi = multi_q;
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios for keypad_scanner with ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames)
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col, row, key;
   logic        valid, held, multi;
   logic [15:0] pressed = '0;
   int          vectors = 0;
   int          errors = 0;

   keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Col(col), .o_Row(row),
      .o_Key(key), .o_Valid(valid), .o_Held(held), .o_Multi(multi)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low while its row is driven low
   always_comb begin
      col = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
   end

   // Holds reset for n cycles and releases it just after a falling edge (cycle 0 of a scenario)
   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      logic [3:0] one = 4'b0001;
      logic [3:0] exp;
      pressed = '0;
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         vectors++;
         if (row !== 4'b1111 || key !== 4'd0 || valid !== 1'b0 || held !== 1'b0 || multi !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: row=%b key=%0d valid=%b held=%b multi=%b, want 1111 0 0 0 0", row, key, valid, held, multi);
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         exp = ~(one << (((i-1)/4) % 4));
         vectors++;
         if (row !== exp || valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_rows cycle %0d: row=%b valid=%b, want row=%b valid=0", i, row, valid, exp);
         end
      end
   endtask

   task automatic test_single_key;
      int nv = 0, vc = 0;
      logic [3:0] vk = '0;
      pressed = 16'h0200;
      do_reset(5);
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (valid) begin
            nv++;
            if (nv == 1) begin vc = i; vk = key; end
         end
         if (i == 128) pressed = '0;
         if (i == 48 || i == 49 || i == 176 || i == 177) begin
            vectors++;
            if (held !== (i == 49 || i == 176)) begin
               errors++;
               $display("FAIL single_held cycle %0d: held=%b, want %b", i, held, (i == 49 || i == 176));
            end
         end
      end
      vectors++;
      if (nv != 1 || vc != 49 || vk !== 4'd9) begin
         errors++;
         $display("FAIL single_report: count=%0d cycle=%0d key=%0d, want 1 49 9", nv, vc, vk);
      end
      vectors++;
      if (key !== 4'd9) begin
         errors++;
         $display("FAIL single_key_hold: key=%0d, want 9", key);
      end
   endtask

   task automatic test_short_press;
      int nv = 0;
      pressed = 16'h0040;
      do_reset(5);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (valid) nv++;
         if (i == 32) pressed = '0;
      end
      vectors++;
      if (nv != 0 || held !== 1'b0) begin
         errors++;
         $display("FAIL short_press: count=%0d held=%b, want 0 0", nv, held);
      end
   endtask

   task automatic test_bounce;
      int nv = 0, nh = 0;
      pressed = 16'h0200;
      do_reset(5);
      for (int i = 1; i <= 180; i++) begin
         @(negedge clk);
         if (valid) nv++;
         if (held) nh++;
         if (i % 16 == 0 && i < 160) pressed = pressed ^ 16'h0200;
         if (i == 160) pressed = '0;
      end
      vectors++;
      if (nv != 0) begin
         errors++;
         $display("FAIL bounce_valid: count=%0d, want 0", nv);
      end
      vectors++;
      if (nh != 0) begin
         errors++;
         $display("FAIL bounce_held: held cycles=%0d, want 0", nh);
      end
   endtask

   task automatic test_multi;
      int nv = 0, vc = 0;
      logic [3:0] vk = '0;
      pressed = 16'h0021;
      do_reset(5);
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (valid) begin
            nv++;
            if (nv == 1) begin vc = i; vk = key; end
         end
         if (i == 16 || i == 17 || i == 48 || i == 65) begin
            vectors++;
            if (multi !== (i == 17 || i == 48)) begin
               errors++;
               $display("FAIL multi_flag cycle %0d: multi=%b, want %b", i, multi, (i == 17 || i == 48));
            end
         end
         if (i == 48) pressed = 16'h0001;
      end
      vectors++;
      if (nv != 1 || vc != 97 || vk !== 4'd0) begin
         errors++;
         $display("FAIL multi_report: count=%0d cycle=%0d key=%0d, want 1 97 0", nv, vc, vk);
      end
   endtask

   task automatic test_reset_midpress;
      int nv = 0, c1 = 0, c2 = 0;
      logic [3:0] k2 = '0;
      pressed = 16'h0200;
      do_reset(5);
      for (int i = 1; i <= 130; i++) begin
         @(negedge clk);
         if (valid) begin
            nv++;
            if (nv == 1) c1 = i;
            if (nv == 2) begin c2 = i; k2 = key; end
         end
         if (i == 57) begin
            vectors++;
            if (row !== 4'b1111 || key !== 4'd0 || valid !== 1'b0 || held !== 1'b0 || multi !== 1'b0) begin
               errors++;
               $display("FAIL midreset_state: row=%b key=%0d valid=%b held=%b multi=%b, want 1111 0 0 0 0", row, key, valid, held, multi);
            end
         end
         if (i == 59) begin
            vectors++;
            if (row !== 4'b1110) begin
               errors++;
               $display("FAIL midreset_restart: row=%b, want 1110", row);
            end
         end
         if (i == 106 || i == 107) begin
            vectors++;
            if (held !== (i == 107)) begin
               errors++;
               $display("FAIL midreset_held cycle %0d: held=%b, want %b", i, held, (i == 107));
            end
         end
         if (i == 56) rst = 1'b1;
         if (i == 58) rst = 1'b0;
      end
      vectors++;
      if (nv != 2 || c1 != 49 || c2 != 107 || k2 !== 4'd9) begin
         errors++;
         $display("FAIL midreset_report: count=%0d first=%0d second=%0d key=%0d, want 2 49 107 9", nv, c1, c2, k2);
      end
   endtask

   initial begin
      test_reset;
      test_single_key;
      test_short_press;
      test_bounce;
      test_multi;
      test_reset_midpress;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
